// File: rtl/sbqm_queue_counter.sv
// Bank queue occupancy counter: synchronised, debounced arrival/departure beams,
// saturating count with empty/full flags and an iteratively divided wait-time estimate.

module sbqm_beam_filter #(
  parameter int DEB = 4
) (
  input  logic clk,
  input  logic Resetn,
  input  logic beam_in,
  output logic fall
);
  localparam int CW = (DEB < 2) ? 1 : $clog2(DEB + 1);

  logic          sync1_q, sync2_q, filt_dly_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced level disagrees with the filtered one.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(DEB - 1)) filt_d = sync2_q;
      else                       cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      filt_q     <= 1'b1;
      filt_dly_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= beam_in;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
    end
  end

  assign fall = filt_dly_q & ~filt_q;
endmodule

module sbqm_queue_counter #(
  parameter int N   = 3,
  parameter int TW  = 2,
  parameter int DEB = 4,
  parameter int SVC = 3,
  parameter int WW  = 5
) (
  input  logic          clk,
  input  logic          Resetn,
  input  logic          back_beam,
  input  logic          front_beam,
  input  logic [TW-1:0] tcount,
  output logic [N-1:0]  pcount,
  output logic          empty_flag,
  output logic          full_flag,
  output logic [WW-1:0] wtime,
  output logic          wtime_valid,
  output logic          overflow_evt,
  output logic          underflow_evt
);
  localparam int          NW   = WW + TW;
  localparam int          BCW  = $clog2(WW + 1);
  localparam logic [N-1:0] MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} div_st_e;

  logic [1:0] beam_raw, beam_fall;
  logic       arrive, depart;

  assign beam_raw = {front_beam, back_beam};

  for (genvar i = 0; i < 2; i++) begin : g_beam
    sbqm_beam_filter #(.DEB(DEB)) u_flt (
      .clk     (clk),
      .Resetn  (Resetn),
      .beam_in (beam_raw[i]),
      .fall    (beam_fall[i])
    );
  end

  assign arrive = beam_fall[0];
  assign depart = beam_fall[1];

  // Occupancy count
  logic [N-1:0] pcount_q, pcount_d;
  logic         empty_q, full_q, ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    pcount_d = pcount_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (arrive && !depart) begin
      if (pcount_q != MAX) pcount_d = pcount_q + 1'b1;
      else                 ovf_d    = 1'b1;
    end else if (depart && !arrive) begin
      if (pcount_q != '0)  pcount_d = pcount_q - 1'b1;
      else                 unf_d    = 1'b1;
    end
  end

  // Wait-time divider
  div_st_e        st_q, st_d;
  logic [TW-1:0]  tcnt_q, t_cur, op_t_q, op_t_d, rem_q, rem_d;
  logic [N-1:0]   op_p_q, op_p_d;
  logic [WW-1:0]  dvd_q, dvd_d, wtime_q, wtime_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic           sat_q, sat_d, pend_q, pend_d, valid_q, valid_d;
  logic [NW-1:0]  num;
  logic [TW:0]    trial, diff;
  logic           opnd_chg;

  assign t_cur    = (tcnt_q == '0) ? TW'(1) : tcnt_q;
  assign opnd_chg = (pcount_q != op_p_q) || (t_cur != op_t_q);
  assign num      = (pcount_q == '0) ? '0
                  : NW'(SVC) * (NW'(pcount_q) + NW'(t_cur) - NW'(1));
  assign trial    = {rem_q, dvd_q[WW-1]};
  assign diff     = trial - {1'b0, op_t_q};

  // Remainder starts with the numerator bits above WW; if those already reach T the
  // quotient cannot fit and is flagged for saturation instead.
  always_comb begin
    st_d    = st_q;
    op_p_d  = op_p_q;
    op_t_d  = op_t_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    bit_d   = bit_q;
    sat_d   = sat_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    wtime_d = wtime_q;
    case (st_q)
      S_IDLE: if (opnd_chg) begin
        st_d    = S_LOAD;
        valid_d = 1'b0;
      end
      S_LOAD: begin
        op_p_d = pcount_q;
        op_t_d = t_cur;
        rem_d  = num[NW-1:WW];
        dvd_d  = num[WW-1:0];
        sat_d  = num >= {t_cur, {WW{1'b0}}};
        pend_d = 1'b0;
        bit_d  = '0;
        st_d   = S_DIV;
      end
      S_DIV: begin
        pend_d = pend_q | opnd_chg;
        if (trial >= {1'b0, op_t_q}) begin
          rem_d = diff[TW-1:0];
          dvd_d = {dvd_q[WW-2:0], 1'b1};
        end else begin
          rem_d = trial[TW-1:0];
          dvd_d = {dvd_q[WW-2:0], 1'b0};
        end
        bit_d = bit_q + 1'b1;
        if (bit_q == BCW'(WW - 1)) st_d = S_DONE;
      end
      S_DONE: begin
        wtime_d = sat_q ? '1 : dvd_q;
        if (pend_q || opnd_chg) st_d = S_LOAD;
        else begin
          valid_d = 1'b1;
          st_d    = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      pcount_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      tcnt_q   <= '0;
      st_q     <= S_IDLE;
      op_p_q   <= '0;
      op_t_q   <= TW'(1);
      rem_q    <= '0;
      dvd_q    <= '0;
      bit_q    <= '0;
      sat_q    <= 1'b0;
      pend_q   <= 1'b0;
      valid_q  <= 1'b1;
      wtime_q  <= '0;
    end else begin
      pcount_q <= pcount_d;
      empty_q  <= (pcount_d == '0);
      full_q   <= (pcount_d == MAX);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      tcnt_q   <= tcount;
      st_q     <= st_d;
      op_p_q   <= op_p_d;
      op_t_q   <= op_t_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      bit_q    <= bit_d;
      sat_q    <= sat_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      wtime_q  <= wtime_d;
    end
  end

  assign pcount        = pcount_q;
  assign empty_flag    = empty_q;
  assign full_flag     = full_q;
  assign wtime         = wtime_q;
  assign wtime_valid   = valid_q;
  assign overflow_evt  = ovf_q;
  assign underflow_evt = unf_q;
endmodule

// File: tb/tb_sbqm_queue_counter.sv
// Scoreboard bench for sbqm_queue_counter: stimulus pushes hand-computed expected
// count/event records and wait-time results; a negedge monitor pops and compares them.

module tb_sbqm_queue_counter;
  localparam int N = 3, TW = 2, DEB = 4, SVC = 3, WW = 5;
  localparam int LAT = DEB + 3;
  localparam int WLAT = WW + 3;
  localparam int GAP = 20;

  typedef struct {int cyc; int p; bit e; bit f; bit o; bit u;} ev_t;
  typedef struct {int cyc; int w;} wt_t;

  logic          clk = 1'b0;
  logic          Resetn;
  logic          back_beam, front_beam;
  logic [TW-1:0] tcount;
  logic [N-1:0]  pcount;
  logic          empty_flag, full_flag, wtime_valid, overflow_evt, underflow_evt;
  logic [WW-1:0] wtime;

  ev_t evq[$];
  wt_t wq[$];
  int  cyc = 0;
  int  n_cmp = 0, n_bad = 0;
  int  last_p = 0;
  bit  last_v = 1'b1;

  sbqm_queue_counter #(.N(N), .TW(TW), .DEB(DEB), .SVC(SVC), .WW(WW)) dut (
    .clk           (clk),
    .Resetn        (Resetn),
    .back_beam     (back_beam),
    .front_beam    (front_beam),
    .tcount        (tcount),
    .pcount        (pcount),
    .empty_flag    (empty_flag),
    .full_flag     (full_flag),
    .wtime         (wtime),
    .wtime_valid   (wtime_valid),
    .overflow_evt  (overflow_evt),
    .underflow_evt (underflow_evt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any count change or event pulse, and any rise of wtime_valid, must match the head of its queue.
  always @(negedge clk) begin
    if (!Resetn) begin
      last_p = int'(pcount);
      last_v = wtime_valid;
    end else begin
      if (int'(pcount) != last_p || overflow_evt || underflow_evt) begin
        n_cmp++;
        if (evq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_evt: cyc=%0d p=%0d o=%0b u=%0b, required no event",
                   cyc, pcount, overflow_evt, underflow_evt);
        end else begin
          ev_t e;
          e = evq.pop_front();
          if (cyc != e.cyc || int'(pcount) != e.p || empty_flag != e.e || full_flag != e.f ||
              overflow_evt != e.o || underflow_evt != e.u) begin
            n_bad++;
            $display("FAIL evt: got cyc=%0d p=%0d e=%0b f=%0b o=%0b u=%0b, required cyc=%0d p=%0d e=%0b f=%0b o=%0b u=%0b",
                     cyc, pcount, empty_flag, full_flag, overflow_evt, underflow_evt,
                     e.cyc, e.p, e.e, e.f, e.o, e.u);
          end
        end
      end
      if (wtime_valid && !last_v) begin
        n_cmp++;
        if (wq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_wtime: cyc=%0d wtime=%0d, required no valid rise", cyc, wtime);
        end else begin
          wt_t w;
          w = wq.pop_front();
          if (cyc != w.cyc || int'(wtime) != w.w) begin
            n_bad++;
            $display("FAIL wtime: got cyc=%0d wtime=%0d, required cyc=%0d wtime=%0d",
                     cyc, wtime, w.cyc, w.w);
          end
        end
      end
      last_p = int'(pcount);
      last_v = wtime_valid;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pcount"}, int'(pcount), 0);
    check({tag, "_empty"}, int'(empty_flag), 1);
    check({tag, "_full"}, int'(full_flag), 0);
    check({tag, "_wtime"}, int'(wtime), 0);
    check({tag, "_valid"}, int'(wtime_valid), 1);
    check({tag, "_ovf"}, int'(overflow_evt), 0);
    check({tag, "_unf"}, int'(underflow_evt), 0);
  endtask

  task automatic push_ev(input int c, input int p, input bit o, input bit u);
    ev_t e;
    e.cyc = c; e.p = p; e.e = (p == 0); e.f = (p == 7); e.o = o; e.u = u;
    evq.push_back(e);
  endtask

  task automatic push_w(input int c, input int w);
    wt_t x;
    x.cyc = c; x.w = w;
    wq.push_back(x);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive selected beams low for lo cycles, then high for GAP cycles.
  task automatic pulse(input bit b, input bit f, input int lo, input bit ev, input int p,
                       input bit o, input bit u, input bit hw, input int wt);
    int k;
    @(negedge clk);
    if (b) back_beam = 1'b0;
    if (f) front_beam = 1'b0;
    k = cyc;
    if (ev) push_ev(k + LAT, p, o, u);
    if (hw) push_w(k + LAT + WLAT, wt);
    wait_until(k + lo);
    back_beam = 1'b1;
    front_beam = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  initial begin
    int k, c;
    Resetn = 1'b0;
    back_beam = 1'b1;
    front_beam = 1'b1;
    tcount = 2'd1;
    repeat (2) @(negedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk);
    Resetn = 1'b1;
    repeat (4) @(negedge clk);

    // Three arrivals with one teller
    pulse(1, 0, DEB + 4, 1, 1, 0, 0, 1, 3);
    pulse(1, 0, DEB + 4, 1, 2, 0, 0, 1, 6);
    pulse(1, 0, DEB + 4, 1, 3, 0, 0, 1, 9);

    // Short pulses and glitches are filtered out
    pulse(1, 0, DEB - 2, 0, 0, 0, 0, 0, 0);
    pulse(1, 0, 1, 0, 0, 0, 0, 0, 0);
    pulse(0, 1, 1, 0, 0, 0, 0, 0, 0);

    // Simultaneous arrival and departure cancel
    pulse(1, 1, DEB + 4, 0, 0, 0, 0, 0, 0);

    // p=4 then p=5 with a teller change mid-division: 15 never shown valid, final 3*6/2=9
    pulse(1, 0, DEB + 4, 1, 4, 0, 0, 1, 12);
    @(negedge clk);
    back_beam = 1'b0;
    k = cyc;
    c = k + LAT;
    push_ev(c, 5, 0, 0);
    push_w(c + 15, 9);
    wait_until(k + DEB + 4);
    back_beam = 1'b1;
    wait_until(c + 5);
    tcount = 2'd2;
    repeat (GAP) @(negedge clk);

    // Departure to 4, then reset in the middle of its division
    @(negedge clk);
    front_beam = 1'b0;
    k = cyc;
    c = k + LAT;
    push_ev(c, 4, 0, 0);
    wait_until(k + DEB + 4);
    front_beam = 1'b1;
    wait_until(c + 4);
    Resetn = 1'b0;
    #1 check_reset_vals("midreset");
    tcount = 2'd0;
    repeat (2) @(negedge clk);
    Resetn = 1'b1;
    repeat (4) @(negedge clk);

    // Underflow at 0, then fill to saturation with tcount=0 acting as one teller
    pulse(0, 1, DEB + 4, 1, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 7; i++) pulse(1, 0, DEB + 4, 1, i, 0, 0, 1, 3 * i);
    pulse(1, 0, DEB + 4, 1, 7, 1, 0, 0, 0);
    pulse(1, 0, DEB + 4, 1, 7, 1, 0, 0, 0);

    // Teller changes at a full queue: 3*9/3=9, depart to 6: 3*8/3=8, then 3*7/2=10
    @(negedge clk);
    tcount = 2'd3;
    k = cyc;
    push_w(k + 1 + WLAT, 9);
    repeat (GAP) @(negedge clk);
    pulse(0, 1, DEB + 4, 1, 6, 0, 0, 1, 8);
    @(negedge clk);
    tcount = 2'd2;
    k = cyc;
    push_w(k + 1 + WLAT, 10);
    repeat (GAP) @(negedge clk);

    while (evq.size() > 0) begin
      ev_t e;
      e = evq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_evt: got nothing, required cyc=%0d p=%0d", e.cyc, e.p);
    end
    while (wq.size() > 0) begin
      wt_t w;
      w = wq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_wtime: got nothing, required cyc=%0d wtime=%0d", w.cyc, w.w);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sbqm_queue_counter.md
Name: sbqm_queue_counter

Overview:
Clocked, parametrised successor to the beam-driven people counter for the smart bank queue manager. It synchronises and debounces the back (arrival) and front (departure) photo beams and maintains a saturating occupancy count with empty/full flags. It also computes an estimated wait time from the count and the number of active tellers, using an iterative divider. Outputs feed the Pcount/Wtime display logic.

Parameters:
N, 3, occupancy count width; MAX = 2^N-1
TW, 2, teller-count width
DEB, 4, debounce length in clock cycles (>=1)
SVC, 3, service time per customer, in display units
WW, 5, wait-time output width; integrator guarantees SVC*(MAX+2^TW-2) < 2^WW

Ports:
clk  in  1  system clock, rising edge
Resetn  in  1  asynchronous, active-low reset
back_beam  in  1  asynchronous; 0 = beam interrupted (arrival)
front_beam  in  1  asynchronous; 0 = beam interrupted (departure)
tcount  in  TW  active tellers; quasi-static, 0 treated as 1
pcount  out  N  current occupancy
empty_flag  out  1  1 when pcount==0
full_flag  out  1  1 when pcount==MAX
wtime  out  WW  estimated wait time
wtime_valid  out  1  1 when wtime matches current pcount/tcount
overflow_evt  out  1  one-cycle pulse: arrival rejected at MAX
underflow_evt  out  1  one-cycle pulse: departure rejected at 0

Behaviour:
- Single clock domain; Resetn asynchronous assert, synchronous release by the integrator.
- Reset values: pcount=0, empty_flag=1, full_flag=0, wtime=0, wtime_valid=1, overflow_evt=0, underflow_evt=0. Synchronisers and filtered beams reset to 1; debounce counters and divider reset to 0/IDLE.
- Synchronisation: 2-FF synchroniser per beam. tcount is registered once; tcount==0 maps to T=1.
- Debounce, per beam: the counter increments each cycle that the synced value differs from the filtered value and clears when they match. When it reaches DEB, the filtered value takes the synced value and the counter clears. Pulses shorter than DEB synced cycles are ignored.
- Events: arrive = filtered back falls 1->0; depart = filtered front falls 1->0. Each is one cycle. Rising edges produce no event.
- Latency: a clean beam fall changes pcount on the (DEB+3)th rising edge after the input first samples low.
- Count update, on the edge following an event cycle:
  - arrive & depart together: no change, no evt pulses.
  - arrive only: if pcount<MAX then pcount+1; else hold and pulse overflow_evt.
  - depart only: if pcount>0 then pcount-1; else hold and pulse underflow_evt.
  - No wrap-around in either direction.
- Flags are registered from the next-pcount value, so they change on the same edge as pcount.
- Wait time: wtime = 0 if pcount==0; otherwise floor(SVC*(pcount+T-1)/T).
  - Numerator is held at internal width WW+TW; the quotient saturates to all-ones if it exceeds WW bits (unreachable under the parameter rule).
- Divider FSM:
  - IDLE: on a change of pcount or registered T versus the last-latched operands, go to LOAD and drop wtime_valid.
  - LOAD: latch operands, form the numerator; go to DIV.
  - DIV: restoring shift-subtract, one quotient bit per cycle, WW cycles.
  - DONE: write wtime. If operands changed during LOAD/DIV (pending flag), go to LOAD with valid still low; else set wtime_valid=1 and go to IDLE.
- wtime holds its previous result while wtime_valid=0. Latency from a pcount change to wtime_valid=1 is WW+3 cycles when no further change occurs.
- Resetn asserted mid-operation (debounce or divide) returns all state to reset values immediately; partial results are discarded.

Test Plan:
1. Assert Resetn=0 mid-division with pcount=4 -> all outputs reset values immediately (pcount=0, empty=1, wtime=0, valid=1).
2. tcount=1, three back_beam low pulses of DEB+4 cycles each -> pcount 0->1->2->3; each change on the (DEB+3)th edge after the input falls; wtime=9, valid after WW+3 cycles.
3. back_beam low for DEB-2 cycles, and a 1-cycle glitch -> pcount unchanged, no evt pulses.
4. Nine clean arrivals from 0 -> pcount saturates at 7, full_flag=1; 8th and 9th arrivals each pulse overflow_evt for one cycle. One departure at pcount=0 after reset -> underflow_evt pulse, pcount=0.
5. Both beams fall in the same cycle at pcount=3 -> pcount stays 3, no evt pulses, wtime_valid stays 1.
6. pcount=5, tcount=1; change tcount to 2 three cycles into DIV -> valid stays low through the restart; final wtime=9 with no intermediate value of 15 exposed as valid.
